lumachroma_palette: RTL and testbench
=====================================

Name: lumachroma_palette

Overview:
- Per-pixel colour-to-signal lookup feeding the luma/chroma generator; sits directly upstream of comp_sync.
- Holds 16 entries of {luma[5:0], phase[7:0], amplitude[3:0]}, indexed by the 4-bit pixel colour, with a registered lookup every clk_dot4x cycle.
- Loads chip-dependent defaults through an init sequencer after reset or a chip change.
- Accepts CPU register writes and readback for run-time palette tuning.

Parameters:
- NTSC_LUMA, 96-bit packed (16x6), default luma per colour index for NTSC chips; entry i = bits[6i+5:6i].
- PAL_LUMA, 96-bit packed (16x6), default luma per colour index for PAL chips.
- NTSC_PHASE, 128-bit packed (16x8), default NTSC phase per colour index.
- PAL_PHASE, 128-bit packed (16x8), default PAL phase per colour index.
- DEF_AMP, 64-bit packed (16x4), default amplitude per colour index (both standards).
- BLANK_LUMA, 6'd12, luma driven while busy.

Ports:
- clk_dot4x  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- chip  in  2  chip type; chip[0]=1 selects PAL defaults.
- pixel_color3  in  4  colour index to look up.
- wr_en  in  1  one-cycle CPU write strobe.
- wr_addr  in  6  address map: 0x00-0x0F luma[i], 0x10-0x1F phase[i], 0x20-0x2F amplitude[i], 0x30-0x3F reserved.
- wr_data  in  8  write data; luma uses [5:0], amplitude uses [3:0].
- rd_addr  in  6  readback address, same map as wr_addr.
- rd_data  out  8  readback data, zero-extended; 0 for reserved addresses.
- lumareg_o  out  6  luma for pixel_color3.
- phasereg_o  out  8  phase for pixel_color3.
- amplitudereg_o  out  4  amplitude for pixel_color3.
- busy  out  1  high while the init sequencer runs.
- wr_drop  out  1  one-cycle pulse when a write is discarded.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Outputs: lumareg_o=BLANK_LUMA, phasereg_o=0, amplitudereg_o=0, rd_data=0, busy=1, wr_drop=0.
  - Sequencer enters INIT with idx=0.
  - Palette contents are undefined until INIT completes.
- States: INIT, RUN.
  - INIT: each cycle writes entry idx with defaults (PAL or NTSC tables chosen by the chip[0] value latched on INIT entry) and increments idx.
  - After writing idx=15 the sequencer goes to RUN. INIT therefore takes exactly 16 cycles; busy falls on the first RUN cycle.
  - RUN: on a chip[0] change versus the latched value, the sequencer returns to INIT with idx=0 on the next cycle.
  - A chip[0] change during INIT restarts INIT at idx=0 with the new tables.
  - Changes in chip[1] alone never trigger INIT.
- Lookup (RUN):
  - Registered, latency 1: pixel_color3 sampled at edge N appears on the three outputs after edge N.
  - Index wraps naturally; no bounds logic.
- Lookup (INIT): outputs are forced to BLANK_LUMA/0/0 on the cycle after busy is sampled high.
- Writes:
  - In RUN, wr_en=1 updates the addressed field at the edge. The index is wr_addr[3:0] and the field is selected by wr_addr[5:4].
  - Wider wr_data bits are truncated.
  - Writes to 0x30-0x3F are ignored silently (no wr_drop).
  - wr_en during INIT, including the cycle RUN->INIT is decided, is discarded and wr_drop pulses on the following cycle.
- Write/lookup collision: a write and a lookup of the same index on the same edge returns the OLD value (read-before-write); the new value is visible from the next lookup.
- Readback: rd_data is registered with latency 1 and shows the stored value with the same read-before-write rule. During INIT it reads 0.
- Reset mid-INIT or mid-RUN: same as power-on reset; any write in the reset cycle is ignored without wr_drop.

Test Plan:
- Reset then chip=2'b00 (NTSC), wait 16 cycles -> busy high for exactly 16 cycles; then pixel_color3=1 yields lumareg_o=NTSC_LUMA[1] one cycle later and amplitudereg_o=DEF_AMP[1].
- RUN, write wr_addr=0x05 data=0x3F, then wr_addr=0x15 data=0xA0, wr_addr=0x25 data=0x1C -> lookup of colour 5 gives luma=63, phase=0xA0, amplitude=0xC; rd_addr=0x25 gives rd_data=0x0C.
- Same-edge write 0x03<=0x20 with pixel_color3=3 -> output shows old luma that cycle and 32 on the next lookup.
- Switch chip 2'b00->2'b01 in RUN -> busy rises next cycle for 16 cycles; colour 2 then returns PAL_PHASE[2]. Toggle chip[0] back at INIT idx=7 -> INIT restarts, busy lasts 16 more cycles, NTSC defaults are loaded.
- wr_en during INIT (idx=4) with wr_addr=0x04 -> wr_drop pulses once, and entry 4 equals its default after INIT.
- Assert rst=0 during RUN after custom writes -> outputs go to 12/0/0 and busy=1; after INIT all custom values are replaced by defaults; a write to 0x3A never pulses wr_drop and rd_addr=0x3A reads 0.

Source files
------------

// File: rtl/lumachroma_palette.sv
// Colour-index to luma/phase/amplitude palette with a default-loading init sequencer
// and CPU write/readback access for run-time tuning.
module lumachroma_palette #(
    parameter logic [95:0]  NTSC_LUMA  = {6'd45, 6'd36, 6'd50, 6'd33, 6'd26, 6'd38, 6'd22, 6'd32,
                                          6'd55, 6'd20, 6'd35, 6'd30, 6'd40, 6'd25, 6'd63, 6'd12},
    parameter logic [95:0]  PAL_LUMA   = {6'd47, 6'd37, 6'd52, 6'd34, 6'd27, 6'd40, 6'd23, 6'd33,
                                          6'd57, 6'd21, 6'd37, 6'd31, 6'd42, 6'd24, 6'd63, 6'd12},
    parameter logic [127:0] NTSC_PHASE = {8'd0, 8'd240, 8'd160, 8'd0, 8'd0, 8'd80, 8'd64, 8'd96,
                                          8'd112, 8'd240, 8'd160, 8'd32, 8'd208, 8'd80, 8'd0, 8'd0},
    parameter logic [127:0] PAL_PHASE  = {8'd0, 8'd250, 8'd170, 8'd0, 8'd0, 8'd90, 8'd70, 8'd100,
                                          8'd120, 8'd250, 8'd170, 8'd45, 8'd218, 8'd90, 8'd0, 8'd0},
    parameter logic [63:0]  DEF_AMP    = 64'h0CA0_0A8A_ECAC_AA00,
    parameter logic [5:0]   BLANK_LUMA = 6'd12
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic [1:0] chip,
    input  logic [3:0] pixel_color3,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] lumareg_o,
    output logic [7:0] phasereg_o,
    output logic [3:0] amplitudereg_o,
    output logic       busy,
    output logic       wr_drop
);

    typedef enum logic {StInit, StRun} state_e;

    state_e     state_q;
    logic [3:0] idx_q;
    logic       chip0_q;

    logic [5:0] luma_mem  [16];
    logic [7:0] phase_mem [16];
    logic [3:0] amp_mem   [16];

    logic       chip_chg;
    logic       init_wr;
    logic       run_wr;
    logic       drop;
    logic [5:0] def_luma;
    logic [7:0] def_phase;
    logic [3:0] def_amp;
    logic [7:0] rd_val;

    // Only the standard bit matters for palette defaults.
    logic unused_chip1;
    assign unused_chip1 = chip[1];

    assign chip_chg = chip[0] != chip0_q;
    assign init_wr  = (state_q == StInit) && !chip_chg;
    assign run_wr   = (state_q == StRun) && !chip_chg && wr_en && (wr_addr[5:4] != 2'b11);
    assign drop     = wr_en && ((state_q == StInit) || chip_chg);

    assign def_luma  = chip0_q ? PAL_LUMA[6*idx_q +: 6]  : NTSC_LUMA[6*idx_q +: 6];
    assign def_phase = chip0_q ? PAL_PHASE[8*idx_q +: 8] : NTSC_PHASE[8*idx_q +: 8];
    assign def_amp   = DEF_AMP[4*idx_q +: 4];

    always_comb begin
        rd_val = '0;
        case (rd_addr[5:4])
            2'b00:   rd_val = {2'b00, luma_mem[rd_addr[3:0]]};
            2'b01:   rd_val = phase_mem[rd_addr[3:0]];
            2'b10:   rd_val = {4'h0, amp_mem[rd_addr[3:0]]};
            default: rd_val = '0;
        endcase
    end

    // Palette storage carries no reset; INIT defines every entry before RUN.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            if (init_wr) begin
                luma_mem[idx_q]  <= def_luma;
                phase_mem[idx_q] <= def_phase;
                amp_mem[idx_q]   <= def_amp;
            end else if (run_wr) begin
                case (wr_addr[5:4])
                    2'b00:   luma_mem[wr_addr[3:0]]  <= wr_data[5:0];
                    2'b01:   phase_mem[wr_addr[3:0]] <= wr_data;
                    2'b10:   amp_mem[wr_addr[3:0]]   <= wr_data[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (!rst) begin
            state_q        <= StInit;
            idx_q          <= 4'd0;
            chip0_q        <= chip[0];
            busy           <= 1'b1;
            wr_drop        <= 1'b0;
            lumareg_o      <= BLANK_LUMA;
            phasereg_o     <= 8'd0;
            amplitudereg_o <= 4'd0;
            rd_data        <= 8'd0;
        end else begin
            wr_drop <= drop;

            if (chip_chg) begin
                state_q <= StInit;
                idx_q   <= 4'd0;
                chip0_q <= chip[0];
                busy    <= 1'b1;
            end else if (state_q == StInit) begin
                idx_q <= idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_q <= StRun;
                    busy    <= 1'b0;
                end
            end

            // Lookup reads the array before this edge's write lands.
            if (state_q == StInit) begin
                lumareg_o      <= BLANK_LUMA;
                phasereg_o     <= 8'd0;
                amplitudereg_o <= 4'd0;
                rd_data        <= 8'd0;
            end else begin
                lumareg_o      <= luma_mem[pixel_color3];
                phasereg_o     <= phase_mem[pixel_color3];
                amplitudereg_o <= amp_mem[pixel_color3];
                rd_data        <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_lumachroma_palette.sv
// Scoreboard bench for lumachroma_palette: stimulus queues expected outputs with a due
// cycle, a monitor compares them after each rising edge.
module tb_lumachroma_palette;

    localparam logic [95:0]  T_NTSC_LUMA  = {6'd45, 6'd36, 6'd50, 6'd33, 6'd26, 6'd38, 6'd22,
        6'd32, 6'd55, 6'd20, 6'd35, 6'd30, 6'd40, 6'd25, 6'd63, 6'd12};
    localparam logic [95:0]  T_PAL_LUMA   = {6'd47, 6'd37, 6'd52, 6'd34, 6'd27, 6'd40, 6'd23,
        6'd33, 6'd57, 6'd21, 6'd37, 6'd31, 6'd42, 6'd24, 6'd63, 6'd12};
    localparam logic [127:0] T_NTSC_PHASE = {8'd0, 8'd240, 8'd160, 8'd0, 8'd0, 8'd80, 8'd64,
        8'd96, 8'd112, 8'd240, 8'd160, 8'd32, 8'd208, 8'd80, 8'd0, 8'd0};
    localparam logic [127:0] T_PAL_PHASE  = {8'd0, 8'd250, 8'd170, 8'd0, 8'd0, 8'd90, 8'd70,
        8'd100, 8'd120, 8'd250, 8'd170, 8'd45, 8'd218, 8'd90, 8'd0, 8'd0};
    localparam logic [63:0]  T_DEF_AMP    = 64'h0CA0_0A8A_ECAC_AA00;

    localparam int SLuma = 0, SPhase = 1, SAmp = 2, SRd = 3, SBusy = 4, SDrop = 5;

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] chip = 2'b00;
    logic [3:0] pixel_color3 = 4'd0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic [7:0] wr_data = 8'd0;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;
    logic [5:0] lumareg_o;
    logic [7:0] phasereg_o;
    logic [3:0] amplitudereg_o;
    logic       busy;
    logic       wr_drop;

    always #5 clk_dot4x = ~clk_dot4x;

    lumachroma_palette #(
        .NTSC_LUMA  (T_NTSC_LUMA),
        .PAL_LUMA   (T_PAL_LUMA),
        .NTSC_PHASE (T_NTSC_PHASE),
        .PAL_PHASE  (T_PAL_PHASE),
        .DEF_AMP    (T_DEF_AMP),
        .BLANK_LUMA (6'd12)
    ) dut (
        .clk_dot4x      (clk_dot4x),
        .rst            (rst),
        .chip           (chip),
        .pixel_color3   (pixel_color3),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .lumareg_o      (lumareg_o),
        .phasereg_o     (phasereg_o),
        .amplitudereg_o (amplitudereg_o),
        .busy           (busy),
        .wr_drop        (wr_drop)
    );

    typedef struct {
        int    due;
        int    sel;
        int    exp;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    function automatic int observe(int sel);
        int v;
        case (sel)
            SLuma:   v = int'(lumareg_o);
            SPhase:  v = int'(phasereg_o);
            SAmp:    v = int'(amplitudereg_o);
            SRd:     v = int'(rd_data);
            SBusy:   v = int'(busy);
            default: v = int'(wr_drop);
        endcase
        return v;
    endfunction

    always @(posedge clk_dot4x) begin
        #1;
        cyc++;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                n_run++;
                if (observe(sbq[i].sel) != sbq[i].exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %0d, expected %0d", sbq[i].name, cyc,
                             observe(sbq[i].sel), sbq[i].exp);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic expect_at(input int sel, input int val, input int dly, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.exp  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_dot4x);
    endtask

    task automatic expect_busy_window(input int hi_cycles, input string name);
        for (int i = 1; i <= hi_cycles; i++) expect_at(SBusy, 1, i, name);
        expect_at(SBusy, 0, hi_cycles + 1, name);
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        // Power-on reset with a stray write that must not flag a drop.
        tick();
        wr_en = 1'b1; wr_addr = 6'h01; wr_data = 8'h11;
        expect_at(SBusy, 1, 1, "rst_busy");
        expect_at(SLuma, 12, 1, "rst_luma");
        expect_at(SPhase, 0, 1, "rst_phase");
        expect_at(SAmp, 0, 1, "rst_amp");
        expect_at(SRd, 0, 1, "rst_rd");
        expect_at(SDrop, 0, 1, "rst_drop");
        tick();
        rst = 1'b1; wr_en = 1'b0; rd_addr = 6'h01;
        expect_busy_window(15, "init_busy");
        expect_at(SRd, 0, 2, "init_rd_zero");
        expect_at(SLuma, 12, 3, "init_blank");
        tick(16);

        pixel_color3 = 4'd1; rd_addr = 6'h01;
        expect_at(SLuma, 63, 1, "ntsc_luma1");
        expect_at(SAmp, 0, 1, "ntsc_amp1");
        expect_at(SRd, 63, 1, "ntsc_rd_luma1");
        tick();
        pixel_color3 = 4'd7;
        expect_at(SLuma, 55, 1, "ntsc_luma7");
        expect_at(SPhase, 112, 1, "ntsc_phase7");
        expect_at(SAmp, 14, 1, "ntsc_amp7");
        tick();

        // Field writes to colour 5, plus a truncated luma write to colour 6.
        expect_at(SDrop, 0, 1, "run_no_drop");
        cpu_write(6'h05, 8'h3F);
        cpu_write(6'h15, 8'hA0);
        cpu_write(6'h25, 8'h1C);
        cpu_write(6'h06, 8'hC5);
        pixel_color3 = 4'd5; rd_addr = 6'h25;
        expect_at(SLuma, 63, 1, "wr_luma5");
        expect_at(SPhase, 160, 1, "wr_phase5");
        expect_at(SAmp, 12, 1, "wr_amp5");
        expect_at(SRd, 12, 1, "rd_amp5");
        tick();
        pixel_color3 = 4'd6; rd_addr = 6'h15;
        expect_at(SLuma, 5, 1, "wr_luma6_trunc");
        expect_at(SRd, 160, 1, "rd_phase5");
        tick();

        // Same-edge write and lookup: old value first, new value next.
        pixel_color3 = 4'd3; rd_addr = 6'h03;
        expect_at(SLuma, 40, 1, "coll_old_luma");
        expect_at(SRd, 40, 1, "coll_old_rd");
        expect_at(SLuma, 32, 2, "coll_new_luma");
        expect_at(SRd, 32, 2, "coll_new_rd");
        cpu_write(6'h03, 8'h20);
        tick();

        // chip[1] alone never reinitialises.
        chip = 2'b10; pixel_color3 = 4'd5;
        expect_at(SBusy, 0, 1, "chip1_no_init_a");
        expect_at(SBusy, 0, 2, "chip1_no_init_b");
        expect_at(SLuma, 63, 2, "chip1_keeps_custom");
        tick(2);
        chip = 2'b00;
        tick();

        // NTSC -> PAL, with a write on the deciding cycle.
        chip = 2'b01; pixel_color3 = 4'd2; rd_addr = 6'h05;
        wr_en = 1'b1; wr_addr = 6'h02; wr_data = 8'h11;
        expect_busy_window(16, "pal_busy");
        expect_at(SDrop, 1, 1, "switch_drop");
        expect_at(SDrop, 0, 2, "switch_drop_one");
        expect_at(SLuma, 25, 1, "switch_last_lookup");
        expect_at(SLuma, 12, 2, "switch_blank");
        expect_at(SRd, 63, 1, "switch_last_rd");
        expect_at(SRd, 0, 2, "switch_rd_zero");
        tick();
        wr_en = 1'b0;
        tick(16);
        expect_at(SPhase, 90, 1, "pal_phase2");
        expect_at(SLuma, 24, 1, "pal_luma2");
        expect_at(SRd, 37, 1, "pal_rd_luma5");
        tick();

        // PAL -> NTSC with writes during INIT at idx 4 and idx 10.
        chip = 2'b00;
        tick(5);
        wr_en = 1'b1; wr_addr = 6'h04; wr_data = 8'h01;
        expect_at(SDrop, 1, 1, "init_drop_idx4");
        expect_at(SDrop, 0, 2, "init_drop_once");
        tick();
        wr_en = 1'b0;
        tick(5);
        wr_en = 1'b1; wr_addr = 6'h14; wr_data = 8'h77;
        expect_at(SDrop, 1, 1, "init_drop_idx10");
        tick();
        wr_en = 1'b0;
        tick(5);
        pixel_color3 = 4'd4; rd_addr = 6'h14;
        expect_at(SLuma, 30, 1, "drop_luma4_default");
        expect_at(SPhase, 32, 1, "drop_phase4_default");
        expect_at(SRd, 32, 1, "drop_rd_phase4");
        tick();

        // NTSC -> PAL, toggled back at idx 7: INIT restarts with NTSC tables.
        chip = 2'b01;
        expect_busy_window(24, "restart_busy");
        tick(8);
        chip = 2'b00;
        tick(17);
        pixel_color3 = 4'd2; rd_addr = 6'h02;
        expect_at(SPhase, 80, 1, "restart_ntsc_phase2");
        expect_at(SLuma, 25, 1, "restart_ntsc_luma2");
        expect_at(SRd, 25, 1, "restart_rd_luma2");
        tick();

        // Custom values, then reset in RUN with a reserved write in the reset cycle.
        cpu_write(6'h05, 8'h01);
        cpu_write(6'h2A, 8'h03);
        pixel_color3 = 4'd10;
        expect_at(SAmp, 3, 1, "custom_amp10");
        tick();
        rst = 1'b0; wr_en = 1'b1; wr_addr = 6'h3A; wr_data = 8'hFF;
        expect_at(SLuma, 12, 1, "rerst_luma");
        expect_at(SPhase, 0, 1, "rerst_phase");
        expect_at(SAmp, 0, 1, "rerst_amp");
        expect_at(SBusy, 1, 1, "rerst_busy");
        expect_at(SRd, 0, 1, "rerst_rd");
        expect_at(SDrop, 0, 1, "rerst_drop");
        tick();
        rst = 1'b1; wr_en = 1'b0;
        expect_at(SDrop, 0, 1, "rerst_drop_after");
        expect_busy_window(15, "rerst_busy");
        tick(16);
        pixel_color3 = 4'd5; rd_addr = 6'h05;
        expect_at(SLuma, 35, 1, "rerst_luma5_default");
        expect_at(SRd, 35, 1, "rerst_rd_luma5");
        tick();
        pixel_color3 = 4'd10; rd_addr = 6'h2A;
        expect_at(SAmp, 10, 1, "rerst_amp10_default");
        expect_at(SRd, 10, 1, "rerst_rd_amp10");
        tick();

        // Reserved address: silent, no effect, reads zero.
        wr_en = 1'b1; wr_addr = 6'h3A; wr_data = 8'hFF; rd_addr = 6'h3A;
        expect_at(SDrop, 0, 1, "resv_no_drop");
        expect_at(SRd, 0, 1, "resv_rd_zero");
        tick();
        wr_en = 1'b0;
        expect_at(SDrop, 0, 1, "resv_no_drop_late");
        expect_at(SAmp, 10, 1, "resv_amp10_intact");
        expect_at(SLuma, 38, 1, "resv_luma10_intact");
        expect_at(SPhase, 80, 1, "resv_phase10_intact");
        tick(3);

        if (sbq.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
